// File: rtl/chip8_memory.sv
// chip8_memory: CHIP-8 main memory, 4 KiB of byte-addressed RAM.
// After reset it writes the standard 0-F hex font into FONT_BASE, one byte per
// cycle. It then accepts a program image over a valid/ready byte stream into
// PROG_BASE and finally releases the CPU, serving combinational reads and
// single-cycle writes.
// Ports:
//   clk_in, rst_n                   clock (rising edge), async active-low reset
//   rd_memory_address/data          combinational CPU read port
//   wr_memory_address/data, wr_go   CPU write port, accepted only once running
//   load_valid/data/last, load_ready  program image byte stream
//   cpu_run                         CPU released (font and image resident)
//   load_count                      program bytes actually stored
//   load_error                      sticky, image ran past the end of RAM
//   wr_fault                        one-cycle pulse, protected CPU write dropped
module chip8_memory #(
    parameter int          MEM_BYTES   = 4096,
    parameter logic [11:0] FONT_BASE   = 12'h050,
    parameter logic [11:0] PROG_BASE   = 12'h200,
    parameter bit          PROTECT_LOW = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [11:0] rd_memory_address,
    output logic [7:0]  rd_memory_data,
    input  logic [11:0] wr_memory_address,
    input  logic [7:0]  wr_memory_data,
    input  logic        wr_go,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_run,
    output logic [12:0] load_count,
    output logic        load_error,
    output logic        wr_fault
);

    typedef enum logic [1:0] {
        S_FONT = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [6:0] FONT_LAST = 7'd79;

    // Five rows of one glyph packed first-row-in-MSB.
    function automatic logic [39:0] glyph_rows(input logic [3:0] g);
        case (g)
            4'h0:    glyph_rows = 40'hF0_90_90_90_F0;
            4'h1:    glyph_rows = 40'h20_60_20_20_70;
            4'h2:    glyph_rows = 40'hF0_10_F0_80_F0;
            4'h3:    glyph_rows = 40'hF0_10_F0_10_F0;
            4'h4:    glyph_rows = 40'h90_90_F0_10_10;
            4'h5:    glyph_rows = 40'hF0_80_F0_10_F0;
            4'h6:    glyph_rows = 40'hF0_80_F0_90_F0;
            4'h7:    glyph_rows = 40'hF0_10_20_40_40;
            4'h8:    glyph_rows = 40'hF0_90_F0_90_F0;
            4'h9:    glyph_rows = 40'hF0_90_F0_10_F0;
            4'hA:    glyph_rows = 40'hF0_90_F0_90_90;
            4'hB:    glyph_rows = 40'hE0_90_E0_90_E0;
            4'hC:    glyph_rows = 40'hF0_80_80_80_F0;
            4'hD:    glyph_rows = 40'hE0_90_90_90_E0;
            4'hE:    glyph_rows = 40'hF0_80_F0_80_F0;
            4'hF:    glyph_rows = 40'hF0_80_F0_80_80;
            default: glyph_rows = 40'h00_00_00_00_00;
        endcase
    endfunction

    // Select one row (0 = top) of a glyph.
    function automatic logic [7:0] font_byte(input logic [3:0] g, input logic [2:0] row);
        logic [39:0] rows;
        rows = glyph_rows(g);
        case (row)
            3'd0:    font_byte = rows[39:32];
            3'd1:    font_byte = rows[31:24];
            3'd2:    font_byte = rows[23:16];
            3'd3:    font_byte = rows[15:8];
            3'd4:    font_byte = rows[7:0];
            default: font_byte = 8'h00;
        endcase
    endfunction

    logic [7:0]  mem_r [MEM_BYTES];

    state_t      state_r,      state_s;
    logic [6:0]  font_idx_r,   font_idx_s;
    logic [3:0]  font_glyph_r, font_glyph_s;
    logic [2:0]  font_row_r,   font_row_s;
    logic [12:0] ptr_r,        ptr_s;          // bit 12 flags the run past 'hFFF
    logic [12:0] load_count_r, load_count_s;
    logic        load_error_r, load_error_s;
    logic        load_ready_r, load_ready_s;
    logic        cpu_run_r,    cpu_run_s;
    logic        wr_fault_r,   wr_fault_s;

    logic        mem_we_s;
    logic [11:0] mem_addr_s;
    logic [7:0]  mem_data_s;
    logic        xfer_s;
    logic        protect_hit_s;

    assign xfer_s        = load_valid & load_ready_r;
    assign protect_hit_s = PROTECT_LOW && (wr_memory_address < PROG_BASE);

    // Next-state logic and the single RAM write-port mux (font, loader or CPU).
    always_comb begin
        state_s      = state_r;
        font_idx_s   = font_idx_r;
        font_glyph_s = font_glyph_r;
        font_row_s   = font_row_r;
        ptr_s        = ptr_r;
        load_count_s = load_count_r;
        load_error_s = load_error_r;
        wr_fault_s   = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = 12'h000;
        mem_data_s   = 8'h00;
        case (state_r)
            S_FONT: begin
                mem_we_s   = 1'b1;
                mem_addr_s = FONT_BASE + {5'b00000, font_idx_r};
                mem_data_s = font_byte(font_glyph_r, font_row_r);
                if (font_idx_r == FONT_LAST) begin
                    state_s = S_LOAD;
                end else begin
                    font_idx_s = font_idx_r + 7'd1;
                end
                if (font_row_r == 3'd4) begin
                    font_row_s   = 3'd0;
                    font_glyph_s = font_glyph_r + 4'd1;
                end else begin
                    font_row_s = font_row_r + 3'd1;
                end
            end
            S_LOAD: begin
                if (xfer_s) begin
                    // Once the pointer has passed the top of RAM, bytes are
                    // swallowed so the image cannot wrap onto low memory.
                    if (ptr_r[12]) begin
                        load_error_s = 1'b1;
                    end else begin
                        mem_we_s     = 1'b1;
                        mem_addr_s   = ptr_r[11:0];
                        mem_data_s   = load_data;
                        ptr_s        = ptr_r + 13'd1;
                        load_count_s = load_count_r + 13'd1;
                    end
                    if (load_last) begin
                        state_s = S_RUN;
                    end else begin
                        state_s = S_LOAD;
                    end
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_RUN: begin
                if (wr_go) begin
                    if (protect_hit_s) begin
                        wr_fault_s = 1'b1;
                    end else begin
                        mem_we_s   = 1'b1;
                        mem_addr_s = wr_memory_address;
                        mem_data_s = wr_memory_data;
                    end
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_s = S_FONT;
            end
        endcase
        load_ready_s = (state_s == S_LOAD);
        cpu_run_s    = (state_s == S_RUN);
    end

    // Control and status registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_FONT;
            font_idx_r   <= 7'd0;
            font_glyph_r <= 4'd0;
            font_row_r   <= 3'd0;
            ptr_r        <= {1'b0, PROG_BASE};
            load_count_r <= 13'd0;
            load_error_r <= 1'b0;
            load_ready_r <= 1'b0;
            cpu_run_r    <= 1'b0;
            wr_fault_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            font_idx_r   <= font_idx_s;
            font_glyph_r <= font_glyph_s;
            font_row_r   <= font_row_s;
            ptr_r        <= ptr_s;
            load_count_r <= load_count_s;
            load_error_r <= load_error_s;
            load_ready_r <= load_ready_s;
            cpu_run_r    <= cpu_run_s;
            wr_fault_r   <= wr_fault_s;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_data_s;
        end
    end

    // Combinational read: a same-address write shows up only after its edge.
    assign rd_memory_data = mem_r[rd_memory_address];

    assign load_ready = load_ready_r;
    assign cpu_run    = cpu_run_r;
    assign load_count = load_count_r;
    assign load_error = load_error_r;
    assign wr_fault   = wr_fault_r;

endmodule

// File: tb/tb_chip8_memory.sv
// tb_chip8_memory: scoreboard bench for chip8_memory. Stimulus pushes expected
// output values into a queue; a monitor on the falling edge pops and compares.
module tb_chip8_memory;

    localparam int K_RD  = 0;
    localparam int K_LR  = 1;
    localparam int K_RUN = 2;
    localparam int K_CNT = 3;
    localparam int K_ERR = 4;
    localparam int K_WF  = 5;

    typedef struct {
        int          kind;
        logic [12:0] val;
        string       name;
    } exp_t;

    logic        clk_in;
    logic        rst_n;
    logic [11:0] rd_memory_address;
    logic [7:0]  rd_memory_data;
    logic [11:0] wr_memory_address;
    logic [7:0]  wr_memory_data;
    logic        wr_go;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        cpu_run;
    logic [12:0] load_count;
    logic        load_error;
    logic        wr_fault;

    exp_t sb_q[$];
    int   checks;
    int   failures;

    chip8_memory dut (
        .clk_in            (clk_in),
        .rst_n             (rst_n),
        .rd_memory_address (rd_memory_address),
        .rd_memory_data    (rd_memory_data),
        .wr_memory_address (wr_memory_address),
        .wr_memory_data    (wr_memory_data),
        .wr_go             (wr_go),
        .load_valid        (load_valid),
        .load_data         (load_data),
        .load_last         (load_last),
        .load_ready        (load_ready),
        .cpu_run           (cpu_run),
        .load_count        (load_count),
        .load_error        (load_error),
        .wr_fault          (wr_fault)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Monitor: every falling edge, compare all queued expectations.
    always @(negedge clk_in) begin
        exp_t        e;
        logic [12:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_RD:    act = {5'd0, rd_memory_data};
                K_LR:    act = {12'd0, load_ready};
                K_RUN:   act = {12'd0, cpu_run};
                K_CNT:   act = load_count;
                K_ERR:   act = {12'd0, load_error};
                K_WF:    act = {12'd0, wr_fault};
                default: act = 13'h1FFF;
            endcase
            checks = checks + 1;
            if (act !== e.val) begin
                failures = failures + 1;
                $display("FAIL %s: actual=0x%0h expected=0x%0h", e.name, act, e.val);
            end
        end
    end

    function automatic logic [7:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return b ^ 8'h5A;
    endfunction

    task automatic push(input int k, input logic [12:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [12:0] act, input logic [12:0] exp_v, input string n);
        checks = checks + 1;
        if (act !== exp_v) begin
            failures = failures + 1;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", n, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_in);
        #1;
    endtask

    task automatic rd_push(input logic [11:0] a, input logic [7:0] v, input string n);
        rd_memory_address = a;
        push(K_RD, {5'd0, v}, n);
    endtask

    task automatic read_chk(input logic [11:0] a, input logic [7:0] v, input string n);
        rd_push(a, v, n);
        settle();
    endtask

    // Count 80 font edges after reset release; load_ready rises after the 80th.
    task automatic font_wait(input string n);
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 79) push(K_LR, 13'd0, {n, "_ready_early"});
            if (c == 80) begin
                push(K_LR, 13'd1, {n, "_ready_rise"});
                chk({12'd0, load_ready}, 13'd1, {n, "_ready_after_wait"});
            end
        end
    endtask

    // One CPU write: check old read before the edge, new read and fault after.
    task automatic wr_cycle(input logic [11:0] a, input logic [7:0] d,
                            input logic [7:0] old_v, input logic [7:0] new_v,
                            input logic fault, input bit chk_rd, input string n);
        tick();
        wr_go = 1'b1;
        wr_memory_address = a;
        wr_memory_data = d;
        rd_memory_address = a;
        if (chk_rd) push(K_RD, {5'd0, old_v}, {n, "_old"});
        push(K_WF, 13'd0, {n, "_fault_pre"});
        settle();
        tick();
        wr_go = 1'b0;
        if (chk_rd) push(K_RD, {5'd0, new_v}, {n, "_new"});
        push(K_WF, {12'd0, fault}, {n, "_fault"});
        settle();
        tick();
        push(K_WF, 13'd0, {n, "_fault_post"});
        settle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        rd_memory_address = 12'h000;
        wr_memory_address = 12'h000;
        wr_memory_data = 8'h00;
        wr_go = 1'b0;
        load_valid = 1'b0;
        load_data = 8'h00;
        load_last = 1'b0;

        // Reset state.
        push(K_LR,  13'd0, "rst_load_ready");
        push(K_RUN, 13'd0, "rst_cpu_run");
        push(K_CNT, 13'd0, "rst_load_count");
        push(K_ERR, 13'd0, "rst_load_error");
        push(K_WF,  13'd0, "rst_wr_fault");
        settle();
        chk({12'd0, load_ready}, 13'd0, "rst_direct_load_ready");
        chk({12'd0, cpu_run},    13'd0, "rst_direct_cpu_run");
        chk(load_count,          13'd0, "rst_direct_load_count");
        chk({12'd0, load_error}, 13'd0, "rst_direct_load_error");
        chk({12'd0, wr_fault},   13'd0, "rst_direct_wr_fault");

        // Phase A: font preload, then oversize image.
        tick();
        rst_n = 1'b1;
        font_wait("fontA");
        settle();
        read_chk(12'h050, 8'hF0, "font_050");
        read_chk(12'h055, 8'h20, "font_055");
        read_chk(12'h09B, 8'hF0, "font_09B");
        read_chk(12'h09F, 8'h80, "font_09F");

        load_valid = 1'b1;
        for (int i = 0; i <= 3584; i++) begin
            load_data = pat(i);
            load_last = (i == 3584);
            @(posedge clk_in);
            #1;
            if (i == 3583) begin
                push(K_ERR, 13'd0, "ovf_err_before");
                push(K_CNT, 13'd3584, "ovf_count_full");
                push(K_RUN, 13'd0, "ovf_run_before");
            end
            if (i == 3584) begin
                push(K_ERR, 13'd1, "ovf_err_set");
                push(K_CNT, 13'd3584, "ovf_count_sat");
                push(K_RUN, 13'd1, "ovf_run");
                push(K_LR,  13'd0, "ovf_ready_low");
            end
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        settle();
        read_chk(12'h200, 8'h5A, "ovf_mem_200");
        read_chk(12'h201, 8'h5B, "ovf_mem_201");
        read_chk(12'hFFF, 8'hA5, "ovf_mem_FFF");

        // Phase B: valid held during font, two bytes, then async reset.
        rst_n = 1'b0;
        load_valid = 1'b1;
        load_data = 8'hAA;
        push(K_LR,  13'd0, "rstB_ready");
        push(K_RUN, 13'd0, "rstB_run");
        push(K_ERR, 13'd0, "rstB_err");
        push(K_CNT, 13'd0, "rstB_count");
        settle();
        tick();
        rst_n = 1'b1;
        font_wait("fontB");
        rd_push(12'h200, 8'h5A, "early_valid_no_xfer");
        tick();
        load_data = 8'hBB;
        push(K_CNT, 13'd1, "early_valid_count1");
        rd_push(12'h200, 8'hAA, "early_valid_xfer");
        tick();
        load_valid = 1'b0;
        push(K_CNT, 13'd2, "midload_count2");
        push(K_LR,  13'd1, "midload_ready");
        settle();
        tick();
        rst_n = 1'b0;
        push(K_LR,  13'd0, "async_rst_ready");
        push(K_CNT, 13'd0, "async_rst_count");
        push(K_RUN, 13'd0, "async_rst_run");
        settle();
        tick();
        rst_n = 1'b1;
        font_wait("fontC");
        settle();
        read_chk(12'h201, 8'hBB, "keep_mem_201");
        read_chk(12'h050, 8'hF0, "refont_050");

        // Phase C: normal 4-byte image.
        for (int j = 0; j < 4; j++) begin
            load_valid = 1'b1;
            case (j)
                0:       load_data = 8'h00;
                1:       load_data = 8'hE0;
                2:       load_data = 8'h12;
                default: load_data = 8'h00;
            endcase
            load_last = (j == 3);
            @(posedge clk_in);
            #1;
            push(K_CNT, 13'(j + 1), "img_count");
            push(K_RUN, (j == 3) ? 13'd1 : 13'd0, "img_run");
            push(K_LR,  (j == 3) ? 13'd0 : 13'd1, "img_ready");
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        settle();
        read_chk(12'h200, 8'h00, "img_mem_200");
        read_chk(12'h201, 8'hE0, "img_mem_201");
        read_chk(12'h202, 8'h12, "img_mem_202");
        read_chk(12'h203, 8'h00, "img_mem_203");
        read_chk(12'h204, 8'h5E, "img_mem_204");
        push(K_ERR, 13'd0, "img_err");
        settle();

        // Phase D: CPU writes in S_RUN.
        wr_cycle(12'h300, 8'hAB, 8'h5A, 8'hAB, 1'b0, 1'b1, "wr300");
        wr_cycle(12'h200, 8'h42, 8'h00, 8'h42, 1'b0, 1'b1, "wr200_edge");
        wr_cycle(12'h050, 8'h00, 8'hF0, 8'hF0, 1'b1, 1'b1, "wr050_prot");
        wr_cycle(12'h010, 8'h77, 8'h00, 8'h00, 1'b1, 1'b0, "wr010_prot");
        wr_cycle(12'h1FF, 8'h33, 8'h00, 8'h00, 1'b1, 1'b0, "wr1FF_prot");

        tick();
        wr_go = 1'b1;
        wr_memory_address = 12'h301;
        wr_memory_data = 8'h11;
        settle();
        tick();
        wr_memory_address = 12'h302;
        wr_memory_data = 8'h22;
        settle();
        tick();
        wr_go = 1'b0;
        settle();
        read_chk(12'h301, 8'h11, "held_wr_301");
        read_chk(12'h302, 8'h22, "held_wr_302");
        read_chk(12'h303, 8'h59, "held_wr_303");

        // Loader is closed once running.
        load_valid = 1'b1;
        load_data = 8'h99;
        tick();
        push(K_CNT, 13'd4, "run_no_load_count");
        push(K_LR,  13'd0, "run_no_load_ready");
        push(K_RUN, 13'd1, "run_stays");
        settle();
        load_valid = 1'b0;
        read_chk(12'h204, 8'h5E, "run_no_load_mem");

        settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
